// File: rtl/riscv_pkg.sv
// Shared fetch-side types: address width, NOP encoding, sequencer states and FIFO payload.
package riscv_pkg;

    localparam int unsigned ALEN  = 32;
    localparam int unsigned ILEN  = 32;
    localparam logic [ILEN-1:0] NOP_INSTR = 32'h00000013;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2,
        HALT  = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic [ILEN-1:0] instr;
        logic [ALEN-1:0] pc;
        logic            fault;
    } fetch_entry_t;

    localparam fetch_entry_t IDLE_ENTRY = '{instr: NOP_INSTR, pc: '0, fault: 1'b0};

endpackage

// File: rtl/fetch_sequencer_if.sv
// Bundle of ROM, control and decode-side handshake signals around the fetch sequencer.
interface fetch_sequencer_if
    import riscv_pkg::*;
    ;

    logic            imem_en;
    logic [ALEN-1:0] imem_addr;
    logic [ILEN-1:0] imem_rdata;

    logic            redirect_valid;
    logic [ALEN-1:0] redirect_pc;
    logic            halt_req;
    logic            halted;

    logic            out_valid;
    logic            out_ready;
    logic [ILEN-1:0] out_instr;
    logic [ALEN-1:0] out_pc;
    logic            out_fault;

    modport master (
        output imem_en, imem_addr,
        input  imem_rdata,
        input  redirect_valid, redirect_pc, halt_req,
        output halted,
        output out_valid, out_instr, out_pc, out_fault,
        input  out_ready
    );

    modport slave (
        input  imem_en, imem_addr,
        output imem_rdata,
        output redirect_valid, redirect_pc, halt_req,
        input  halted,
        input  out_valid, out_instr, out_pc, out_fault,
        output out_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// Fetch buffer: synchronous FIFO of fetch entries with flush and a registered head.
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  fetch_entry_t push_data,
    output logic         full,
    output logic         will_empty,
    output logic         head_valid,
    output fetch_entry_t head
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;

    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr, rd_ptr_nxt, wr_ptr_nxt;
    logic [CW-1:0] count, count_nxt;
    fetch_entry_t  head_nxt;
    logic          write_en;

    assign write_en   = push && !flush;
    assign full       = (count == CW'(DEPTH));
    assign will_empty = (count_nxt == '0);

    // Pointer and occupancy bookkeeping; flush wins over any push/pop.
    always_comb begin
        rd_ptr_nxt = rd_ptr;
        wr_ptr_nxt = wr_ptr;
        count_nxt  = count;
        if (flush) begin
            rd_ptr_nxt = '0;
            wr_ptr_nxt = '0;
            count_nxt  = '0;
        end else begin
            if (push) wr_ptr_nxt = wr_ptr + PW'(1);
            if (pop)  rd_ptr_nxt = rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count_nxt = count + CW'(1);
                2'b01:   count_nxt = count - CW'(1);
                default: count_nxt = count;
            endcase
        end
    end

    // Next head: the entry being written this cycle bypasses storage when it lands at the head slot.
    always_comb begin
        head_nxt = IDLE_ENTRY;
        if (count_nxt == '0) begin
            head_nxt = IDLE_ENTRY;
        end else if (write_en && (wr_ptr == rd_ptr_nxt)) begin
            head_nxt = push_data;
        end else begin
            head_nxt = mem[rd_ptr_nxt];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= IDLE_ENTRY;
        end else if (write_en) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            head_valid <= 1'b0;
            head       <= IDLE_ENTRY;
        end else begin
            rd_ptr     <= rd_ptr_nxt;
            wr_ptr     <= wr_ptr_nxt;
            count      <= count_nxt;
            head_valid <= (count_nxt != '0);
            head       <= head_nxt;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch-side controller: owns the PC, reads the combinational ROM once per cycle and
// buffers {instr, pc, fault} for decode, handling redirects, debug halt and fetch faults.
module fetch_sequencer
    import riscv_pkg::*;
#(
    parameter logic [ALEN-1:0] RESET_PC   = '0,
    parameter int unsigned     IMEM_WORDS = 4096,
    parameter int unsigned     FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    fetch_sequencer_if.master  bus
);

    fetch_state_t    state, state_nxt;
    logic [ALEN-1:0] pc, pc_nxt;
    logic [ALEN-1:0] word_idx;
    logic            pc_fault;
    logic            redirect_take;
    logic            fetch_slot;
    logic            push, pop, flush;
    fetch_entry_t    push_data;
    logic            fifo_full, fifo_will_empty, head_valid;
    fetch_entry_t    head;
    logic            halted;

    // Fault check happens ahead of any ROM access so a bad PC never reaches the ROM.
    assign word_idx      = pc >> 2;
    assign pc_fault      = (pc[1:0] != 2'b00) || (word_idx >= ALEN'(IMEM_WORDS));
    assign redirect_take = bus.redirect_valid && (state != BOOT);
    assign pop           = head_valid && bus.out_ready;

    // A fetch slot exists only in RUN with no redirect/halt pending and room (or a same-cycle pop).
    assign fetch_slot = (state == RUN) && !bus.redirect_valid && !bus.halt_req
                        && (!fifo_full || pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= BOOT;
            pc     <= RESET_PC;
            halted <= 1'b0;
        end else begin
            state  <= state_nxt;
            pc     <= pc_nxt;
            halted <= (state_nxt == HALT) && fifo_will_empty;
        end
    end

    always_comb begin
        state_nxt = state;
        if (redirect_take) begin
            state_nxt = bus.halt_req ? HALT : RUN;
        end else begin
            case (state)
                BOOT:    state_nxt = RUN;
                RUN: begin
                    if (bus.halt_req)              state_nxt = HALT;
                    else if (fetch_slot && pc_fault) state_nxt = FAULT;
                end
                FAULT:   if (bus.halt_req)  state_nxt = HALT;
                HALT:    if (!bus.halt_req) state_nxt = RUN;
                default: state_nxt = BOOT;
            endcase
        end
    end

    always_comb begin
        bus.imem_en   = 1'b0;
        bus.imem_addr = pc;
        push          = 1'b0;
        flush         = 1'b0;
        push_data     = '{instr: bus.imem_rdata, pc: pc, fault: 1'b0};
        pc_nxt        = pc;
        if (redirect_take) begin
            flush  = 1'b1;
            pc_nxt = bus.redirect_pc;
        end else if (fetch_slot) begin
            push = 1'b1;
            if (pc_fault) begin
                push_data = '{instr: NOP_INSTR, pc: pc, fault: 1'b1};
            end else begin
                bus.imem_en = 1'b1;
                pc_nxt      = pc + ALEN'(4);
            end
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .push       (push),
        .pop        (pop),
        .push_data  (push_data),
        .full       (fifo_full),
        .will_empty (fifo_will_empty),
        .head_valid (head_valid),
        .head       (head)
    );

    assign bus.out_valid = head_valid;
    assign bus.out_instr = head.instr;
    assign bus.out_pc    = head.pc;
    assign bus.out_fault = head.fault;
    assign bus.halted    = halted;

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Fetch-side controller that sequences the asynchronous-read instruction ROM. It owns the program counter and issues one ROM read per cycle, capturing the same-cycle instruction word together with its PC into a small FIFO. It presents those pairs to decode over a valid/ready handshake. Redirects from execute, debug halt and fetch faults are handled here so that the ROM itself stays a pure combinational lookup.

## Interface
- RESET_PC, default 0: PC loaded on reset; must be word-aligned.
- IMEM_WORDS, default 4096: ROM depth in 32-bit words; the legal word index range is 0..IMEM_WORDS-1.
- FIFO_DEPTH, default 2: fetch buffer entries, a power of two, at least 2.
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  reset, asynchronous and active-low.
- imem_en  out  1  ROM read enable.
- imem_addr  out  ALEN  byte address to the ROM.
- imem_rdata  in  32  ROM read data, valid in the same cycle as imem_addr.
- redirect_valid  in  1  PC redirect from execute or trap.
- redirect_pc  in  ALEN  redirect target.
- halt_req  in  1  level-sensitive debug halt request.
- halted  out  1  fetch is stopped and the FIFO is empty.
- out_valid  out  1  FIFO head is valid.
- out_ready  in  1  decode accepts the head.
- out_instr  out  32  head instruction.
- out_pc  out  ALEN  head PC.
- out_fault  out  1  head is a fetch-fault marker.

## Operation
- States:
  - BOOT: one cycle after reset release, then RUN.
  - RUN: normal fetch.
  - FAULT: fetch stopped after a fault.
  - HALT: fetch stopped on halt_req.
- Push condition, RUN only: push occurs when the FIFO is not full, or when a pop happens this cycle. On a push:
  - imem_en=1 and imem_addr=pc.
  - {imem_rdata, pc, fault=0} is written into the FIFO.
  - pc <= pc+4, wrapping modulo 2^ALEN.
- A push is blocked in every cycle where redirect_valid=1 or halt_req=1. In those cycles imem_en=0 and imem_addr=pc.
- Fault check, evaluated before any ROM read:
  - A fault occurs if pc[1:0]!=0, or if (pc>>2) >= IMEM_WORDS.
  - On a fault: push {32'h00000013, pc, fault=1}, set imem_en=0, go to FAULT.
  - The push obeys the same FIFO-space rule as a normal push.
- Redirect, accepted in any state except BOOT:
  - Flush the FIFO; out_valid falls the next cycle.
  - pc <= redirect_pc.
  - Next state is HALT if halt_req=1, otherwise RUN.
  - Redirect has priority over push, fault and halt.
- Halt:
  - In RUN or FAULT, halt_req=1 moves the block to HALT.
  - In HALT, halted=1 once the FIFO is empty.
  - In HALT, halt_req=0 returns the block to RUN, resuming at the current pc.
  - A halt entered from FAULT resumes into RUN and re-evaluates the fault.
- Pop: when out_valid && out_ready, the head is removed. A pop in the same cycle as a redirect still counts as consumed.
- Reset values: pc=RESET_PC, state=BOOT, FIFO empty, imem_en=0, imem_addr=RESET_PC, out_valid=0, out_instr=32'h00000013, out_pc=0, out_fault=0, halted=0.
- Reset asserted mid-operation immediately clears all state to the reset values; in-flight entries are discarded.

## Timing
- The first imem_en=1 occurs 2 clk edges after rst deasserts (BOOT cycle, then RUN).
- Fetch-to-decode latency is 1 cycle: a word pushed at edge N is visible on out_* after edge N. out_* are driven from registers.
- Throughput is 1 instruction per cycle with out_ready held at 1. A full FIFO with a same-cycle pop still pushes.
- With out_ready=0, exactly FIFO_DEPTH entries are fetched before imem_en drops to 0.
- halted rises the cycle after the last pop completes in HALT.
- imem_addr and imem_en are combinational from pc, state and FIFO status. There is no combinational path from imem_rdata to any output.

## Structure
- riscv_pkg holds:
  - ALEN.
  - The NOP constant 32'h00000013.
  - The state enum fetch_state_t {BOOT, RUN, FAULT, HALT}.
  - A packed fetch_entry_t {instr, pc, fault}.
- One sub-module, fetch_fifo: a synchronous FIFO of fetch_entry_t with flush, push, pop, full, empty and registered head outputs. The PC, FSM and fault logic stay in fetch_sequencer.

## Test plan
- Reset and stream: RESET_PC=0, ROM words 0..3 = A0..A3, out_ready=1 → out_pc 0,4,8,C in consecutive cycles, starting 3 edges after reset release, with instructions A0..A3.
- Backpressure: out_ready=0 for 5 cycles → exactly 2 fetches (pc 0,4), then imem_en=0. Releasing out_ready → pc 8 next, with no duplicates or drops.
- Redirect flush: redirect_valid=1, redirect_pc=0x40 while the FIFO holds pc 8 and C → next out_pc=0x40. pc 8 and C are never presented.
- Misaligned redirect: redirect_pc=0x42 → one entry {NOP, 0x42, fault=1}, then imem_en stays 0. A later redirect to 0x100 → normal fetch resumes at 0x100.
- Out-of-range: IMEM_WORDS=4, pc reaches 0x10 → fault entry at pc 0x10, state FAULT.
- Halt drain and reset: halt_req=1 with 2 entries queued → no new fetch; halted=1 after both pops; release → fetch resumes at next pc. Then assert rst mid-stream → all outputs take their reset values asynchronously.
